// File: rtl/button_event_decoder_if.sv
// Debounced button level in, gesture event pulses out.
interface button_event_decoder_if;
    logic db;
    logic press_p;
    logic release_p;
    logic click_p;
    logic double_p;
    logic long_p;
    logic repeat_p;
    logic held;

    modport master (
        output db,
        input  press_p, release_p, click_p, double_p,
        input  long_p, repeat_p, held
    );

    modport slave (
        input  db,
        output press_p, release_p, click_p, double_p,
        output long_p, repeat_p, held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle gesture pulses
// (press, release, click, double, long, repeat) with its own tick prescaler.
module button_event_decoder #(
    parameter int TICK_M       = 1_000_000,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int DOUBLE_TICKS = 30
) (
    input logic clk,
    input logic reset,
    button_event_decoder_if.slave bus
);
    localparam int MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int MAX_T  = (MAX_LR > DOUBLE_TICKS) ? MAX_LR : DOUBLE_TICKS;
    localparam int CW     = $clog2(MAX_T) + 1;
    localparam int PW     = $clog2(TICK_M);

    typedef enum logic [2:0] {
        IDLE, DOWN1, HOLD, GAP, DOWN2
    } state_t;

    state_t state, state_n;
    logic db_q;
    logic [PW-1:0] presc;
    logic [CW-1:0] cnt;

    logic rise, fall, tick, trans;
    logic reach_long, reach_rep, reach_dbl;
    logic press_d, release_d, click_d, double_d;
    logic long_d, repeat_d, held_d;

    assign rise  = bus.db & ~db_q;
    assign fall  = ~bus.db & db_q;
    assign tick  = (presc == PW'(TICK_M - 1));
    assign trans = (state_n != state);

    // Thresholds fire on the tick that would bring the count to N.
    assign reach_long = tick && (cnt == CW'(LONG_TICKS - 1));
    assign reach_rep  = tick && (cnt == CW'(REPEAT_TICKS - 1));
    assign reach_dbl  = tick && (cnt == CW'(DOUBLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (rise) state_n = DOWN1;
            DOWN1: begin
                if (fall)            state_n = GAP;
                else if (reach_long) state_n = HOLD;
            end
            HOLD:  if (fall) state_n = IDLE;
            GAP: begin
                if (rise)           state_n = DOWN2;
                else if (reach_dbl) state_n = IDLE;
            end
            DOWN2: begin
                if (fall)            state_n = IDLE;
                else if (reach_long) state_n = HOLD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state)
            IDLE:  press_d = rise;
            DOWN1, DOWN2: begin
                release_d = fall;
                long_d    = ~fall & reach_long;
            end
            HOLD: begin
                release_d = fall;
                repeat_d  = ~fall & reach_rep;
            end
            GAP: begin
                press_d  = rise;
                double_d = rise;
                click_d  = ~rise & reach_dbl;
            end
            default: ;
        endcase
        held_d = (state_n == DOWN1) || (state_n == DOWN2) || (state_n == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q          <= 1'b1;
            presc         <= '0;
            cnt           <= '0;
            bus.press_p   <= 1'b0;
            bus.release_p <= 1'b0;
            bus.click_p   <= 1'b0;
            bus.double_p  <= 1'b0;
            bus.long_p    <= 1'b0;
            bus.repeat_p  <= 1'b0;
            bus.held      <= 1'b0;
        end else begin
            db_q <= bus.db;
            if (trans || tick) presc <= '0;
            else               presc <= presc + 1'b1;
            if (trans || repeat_d)   cnt <= '0;
            else if (tick && cnt != '1) cnt <= cnt + 1'b1;
            bus.press_p   <= press_d;
            bus.release_p <= release_d;
            bus.click_p   <= click_d;
            bus.double_p  <= double_d;
            bus.long_p    <= long_d;
            bus.repeat_p  <= repeat_d;
            bus.held      <= held_d;
        end
    end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the debounced push-button level from the switch debouncer and turns it into one-cycle event pulses: press, release, single click, double click, long press and auto-repeat. It sits between the debouncer and the application FSMs, so downstream logic never has to time button gestures itself. It owns its own tick prescaler; no external timebase is required.

## Interface

Parameters:
- `TICK_M`, default 1_000_000: clocks per gesture tick, 10 ms at 100 MHz. Must be ≥ 2.
- `LONG_TICKS`, default 100: ticks a press must last to count as long. Must be ≥ 2.
- `REPEAT_TICKS`, default 20: ticks between auto-repeat pulses while held past long. Must be ≥ 1.
- `DOUBLE_TICKS`, default 30: maximum release-to-press gap, in ticks, for a double click. Must be ≥ 1.

Ports:
- `clk` input 1: the block's only clock. Everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `db` input 1: debounced button level, already synchronous to `clk`. 1 means pressed.
- `press_p` output 1: one-cycle pulse on each accepted press.
- `release_p` output 1: one-cycle pulse on each accepted release.
- `click_p` output 1: one-cycle pulse marking a single click, issued once the double-click window expires.
- `double_p` output 1: one-cycle pulse on the second press of a double click.
- `long_p` output 1: one-cycle pulse when a press reaches `LONG_TICKS`.
- `repeat_p` output 1: one-cycle pulse every `REPEAT_TICKS` while held after `long_p`.
- `held` output 1: level output, high while the FSM considers the button down.

## Operation

- Edge detection:
  - `db_q` holds the previous value of `db`.
  - rise = `db & ~db_q`; fall = `~db & db_q`.
- Prescaler:
  - Counts 0..`TICK_M`-1.
  - `tick` is asserted when the count equals `TICK_M`-1.
  - Cleared on every state transition.
- Tick counter:
  - Width `$clog2` of the largest of the three tick parameters, plus 1.
  - Cleared on every state transition and after every `repeat_p`.
  - Increments on `tick` and saturates; it never wraps.
- FSM states and transitions:
  - IDLE:
    - rise → DOWN1, with `press_p`.
    - fall is ignored.
  - DOWN1:
    - fall → GAP, with `release_p`.
    - count reaches `LONG_TICKS` → HOLD, with `long_p`.
  - HOLD:
    - Each time count reaches `REPEAT_TICKS`: `repeat_p`, and the count clears.
    - fall → IDLE, with `release_p` and no click.
  - GAP:
    - rise → DOWN2, with `press_p` and `double_p`.
    - count reaches `DOUBLE_TICKS` → IDLE, with `click_p`.
  - DOWN2:
    - fall → IDLE, with `release_p` and no click.
    - count reaches `LONG_TICKS` → HOLD, with `long_p`.
- `held` is 1 in DOWN1, DOWN2 and HOLD.
- Simultaneous events:
  - An edge on `db` beats a count threshold in the same cycle.
  - In DOWN1/DOWN2 a fall wins over long: `release_p` is issued, `long_p` is not.
  - In GAP a rise wins over timeout: `double_p` is issued, `click_p` is not.
- Pulse exclusivity: at most one of `click_p`/`double_p`/`long_p`/`repeat_p` is asserted per cycle.

## Timing

- All outputs are registered. They are asserted in the cycle following the edge at which `db` was sampled, so latency from `db` change to pulse is 1 cycle.
- Each pulse is high for exactly one cycle.
- Long press: `long_p` rises exactly `LONG_TICKS*TICK_M` cycles after `press_p` rises.
- Auto-repeat: `repeat_p` rises every `REPEAT_TICKS*TICK_M` cycles after `long_p`.
- Single click: `click_p` rises `DOUBLE_TICKS*TICK_M` cycles after `release_p`.
- Reset values:
  - State IDLE.
  - Prescaler and tick counter 0.
  - All outputs 0.
  - `db_q` = 1, so a button held through reset produces no events until it is released and pressed again.
- Reset asserted mid-gesture: all outputs go to 0 the next cycle, with no `release_p`.

## Test plan

All scenarios use `TICK_M`=4, `LONG_TICKS`=5 (20 cycles), `REPEAT_TICKS`=2 (8 cycles), `DOUBLE_TICKS`=3 (12 cycles).

1. Single click: `db` high 6 cycles then low → `press_p`; `release_p` 6 cycles later; `click_p` 12 cycles after `release_p`. No `double_p` or `long_p`. `held` is high for exactly 6 cycles.
2. Double click: `db` high 6, low 5, high 6, low → `press_p`, `release_p`, then `press_p` and `double_p` in the same cycle, then `release_p`. `click_p` never fires.
3. Long hold: `db` high 40 cycles → `long_p` at +20 cycles from `press_p`; `repeat_p` at +28 and +36; `release_p` at +40; no `click_p` afterwards.
4. Boundaries:
   - `db` falls on the cycle `long_p` would fire → only `release_p`, then GAP.
   - Rise on the cycle `click_p` would fire → `double_p` only.
5. Reset:
   - `db` held high through reset → no `press_p`; release then press → `press_p`.
   - Reset asserted in HOLD → all outputs 0 the next cycle, no `release_p`.
